// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 encodings, ALU function codes, condition codes and CC bit layout.
package y86_pkg;
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_XOR} alu_fn_t;

    localparam logic [3:0] C_ALWAYS = 4'h0;
    localparam logic [3:0] C_LE     = 4'h1;
    localparam logic [3:0] C_L      = 4'h2;
    localparam logic [3:0] C_E      = 4'h3;
    localparam logic [3:0] C_NE     = 4'h4;
    localparam logic [3:0] C_GE     = 4'h5;
    localparam logic [3:0] C_G      = 4'h6;

    localparam int CC_ZF = 2;
    localparam int CC_SF = 1;
    localparam int CC_OF = 0;

    function automatic logic cond_eval(input logic [3:0] f, input logic [2:0] c);
        logic zf, lt;
        zf = c[CC_ZF];
        lt = c[CC_SF] ^ c[CC_OF];
        return (f == C_ALWAYS) ? 1'b1 :
               (f == C_LE)     ? lt | zf :
               (f == C_L)      ? lt :
               (f == C_E)      ? zf :
               (f == C_NE)     ? ~zf :
               (f == C_GE)     ? ~lt :
               (f == C_G)      ? ~lt & ~zf : 1'b0;
    endfunction
endpackage

// File: rtl/y86_alu.sv
// y86_alu: combinational Y86 ALU; subtract is valB plus the two's complement of valA.
module y86_alu
    import y86_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] alu_a_i,
    input  logic [WIDTH-1:0] alu_b_i,
    input  alu_fn_t          fn_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zf_o,
    output logic             sf_o,
    output logic             of_o
);
    logic [WIDTH-1:0] neg_a, sum;
    logic             a_s, b_s, r_s;

    always_comb begin
        neg_a    = ~alu_a_i + {{(WIDTH-1){1'b0}}, 1'b1};
        sum      = alu_b_i + ((fn_i == ALU_SUB) ? neg_a : alu_a_i);
        result_o = (fn_i == ALU_AND) ? (alu_a_i & alu_b_i) :
                   (fn_i == ALU_XOR) ? (alu_a_i ^ alu_b_i) : sum;
        a_s      = alu_a_i[WIDTH-1];
        b_s      = alu_b_i[WIDTH-1];
        r_s      = result_o[WIDTH-1];
        zf_o     = (result_o == '0);
        sf_o     = r_s;
        of_o     = (fn_i == ALU_ADD) ? ((a_s == b_s) && (r_s != a_s)) :
                   (fn_i == ALU_SUB) ? ((a_s != b_s) && (r_s != b_s)) : 1'b0;
    end
endmodule

// File: rtl/y86_execute_stage.sv
// y86_execute_stage: registered Y86-64 Execute stage with CC register,
// jXX/cmovXX condition evaluation and sticky halt / invalid-instruction status.
module y86_execute_stage
    import y86_pkg::*;
#(
    parameter int WIDTH      = 64,
    parameter int STACK_STEP = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [3:0]       icode,
    input  logic [3:0]       ifun,
    input  logic [WIDTH-1:0] valA,
    input  logic [WIDTH-1:0] valB,
    input  logic [WIDTH-1:0] valC,
    output logic             out_valid,
    output logic [3:0]       e_icode,
    output logic [WIDTH-1:0] valE,
    output logic             cnd,
    output logic [2:0]       cc,
    output logic             halted,
    output logic             instr_err
);
    localparam logic [WIDTH-1:0] STEP = WIDTH'(STACK_STEP);

    logic             valid_q, valid_d, cnd_q, cnd_d, halt_q, halt_d, err_q, err_d;
    logic [3:0]       icode_q, icode_d;
    logic [WIDTH-1:0] vale_q, vale_d, alu_a, alu_b, result;
    logic [2:0]       cc_q, cc_d;
    logic             zf, sf, of, accept, bad, is_op;
    alu_fn_t          fn;

    always_comb begin
        is_op = (icode == I_OPQ);
        alu_a = (icode == I_RRMOVQ || is_op)                              ? valA :
                (icode == I_IRMOVQ || icode == I_RMMOVQ || icode == I_MRMOVQ) ? valC :
                (icode == I_CALL   || icode == I_PUSHQ)                   ? -STEP :
                (icode == I_RET    || icode == I_POPQ)                    ? STEP : '0;
        alu_b = (icode == I_RMMOVQ || icode == I_MRMOVQ || is_op || icode == I_CALL ||
                 icode == I_PUSHQ  || icode == I_RET    || icode == I_POPQ) ? valB : '0;
        fn    = is_op ? alu_fn_t'(ifun[1:0]) : ALU_ADD;
    end

    y86_alu #(.WIDTH(WIDTH)) u_alu (
        .alu_a_i  (alu_a),
        .alu_b_i  (alu_b),
        .fn_i     (fn),
        .result_o (result),
        .zf_o     (zf),
        .sf_o     (sf),
        .of_o     (of)
    );

    // Outputs and CC hold on non-accept cycles; only out_valid drops.
    always_comb begin
        accept  = in_valid & ~halt_q & ~err_q;
        bad     = (icode > I_POPQ) || (is_op && ifun > 4'd3);
        valid_d = accept;
        icode_d = accept ? icode : icode_q;
        vale_d  = accept ? (bad ? '0 : result) : vale_q;
        cnd_d   = accept ? ((icode == I_JXX || icode == I_RRMOVQ) && cond_eval(ifun, cc_q)) : cnd_q;
        cc_d    = (accept && is_op && !bad) ? {zf, sf, of} : cc_q;
        halt_d  = halt_q | (accept && icode == I_HALT);
        err_d   = err_q | (accept && bad);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            icode_q <= '0;
            vale_q  <= '0;
            cnd_q   <= 1'b0;
            cc_q    <= 3'b100;
            halt_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            icode_q <= icode_d;
            vale_q  <= vale_d;
            cnd_q   <= cnd_d;
            cc_q    <= cc_d;
            halt_q  <= halt_d;
            err_q   <= err_d;
        end
    end

    assign out_valid = valid_q;
    assign e_icode   = icode_q;
    assign valE      = vale_q;
    assign cnd       = cnd_q;
    assign cc        = cc_q;
    assign halted    = halt_q;
    assign instr_err = err_q;
endmodule
